// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the fabric configuration controller:
// FSM state encoding, the configuration word width and the broadcast-address helper.
package fabric_cfg_pkg;

    // Native width of a configuration word.
    localparam int CFG_WORD_W = 32;

    // Controller state encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } cfg_state_t;

    // True when the low addr_w bits of addr are all ones (broadcast to every tile).
    function automatic logic is_broadcast(input logic [31:0] addr, input int unsigned addr_w);
        logic [31:0] all_ones;
        all_ones = (32'd1 << addr_w) - 32'd1;
        return (addr & all_ones) == all_ones;
    endfunction

endpackage

// File: rtl/fabric_config_ctrl_decode.sv
// cfg_tile_decode: combinational tile-address decoder.
// Produces a one-hot tile select, a broadcast flag (all-ones address) and an
// out-of-range flag (address beyond the last tile and not broadcast).
module cfg_tile_decode
    import fabric_cfg_pkg::*;
#(
    parameter int NUM_TILES = 16,
    parameter int ADDR_W    = 5
) (
    input  logic [ADDR_W-1:0]    addr,
    output logic [NUM_TILES-1:0] onehot,
    output logic                 broadcast,
    output logic                 out_of_range
);

    logic [31:0] addr_ext;

    assign addr_ext     = 32'(addr);
    assign broadcast    = is_broadcast(addr_ext, ADDR_W);
    assign out_of_range = !broadcast && (addr_ext >= 32'(NUM_TILES));

    // One-hot select; all zero when the address does not name a real tile.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            onehot[i] = (addr_ext == 32'(i));
        end
    end

endmodule

// File: rtl/fabric_config_ctrl.sv
// fabric_config_ctrl: sequences configuration words into a column of switch-box tiles.
// Each accepted (address, word) pair is broadcast on config_data, the addressed
// tile's config_en is pulsed for one cycle, then the controller waits a settle
// interval before accepting the next word. fabric_run is held low for the whole
// session and raised once the word flagged last has settled.
// Optional feature macro: CFG_PARITY_EN adds even-parity checking of each word
// (input cfg_parity, sticky output err_parity).
module fabric_config_ctrl
    import fabric_cfg_pkg::*;
#(
    parameter int NUM_TILES     = 16,
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = CFG_WORD_W,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [DATA_W-1:0]    cfg_data,
    input  logic                 cfg_last,
`ifdef CFG_PARITY_EN
    input  logic                 cfg_parity,
    output logic                 err_parity,
`endif
    output logic [DATA_W-1:0]    config_data,
    output logic [NUM_TILES-1:0] config_en,
    output logic                 fabric_run,
    output logic                 done,
    output logic                 err_addr,
    output logic [15:0]          word_count
);

    // Settle counter must hold the value SETTLE_CYCLES.
    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    cfg_state_t           state;
    logic [CNT_W-1:0]     settle_cnt;
    logic                 last_word;

    logic [NUM_TILES-1:0] dec_onehot;
    logic                 dec_broadcast;
    logic                 dec_out_of_range;
    logic                 parity_bad;
    logic                 handshake;
    logic                 apply_word;
    logic [NUM_TILES-1:0] next_en;
    logic [15:0]          count_base;

    // Saturating increment for the session word counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    cfg_tile_decode #(
        .NUM_TILES (NUM_TILES),
        .ADDR_W    (ADDR_W)
    ) u_decode (
        .addr         (cfg_addr),
        .onehot       (dec_onehot),
        .broadcast    (dec_broadcast),
        .out_of_range (dec_out_of_range)
    );

`ifdef CFG_PARITY_EN
    // Even parity: XOR over address, data and the parity bit must be zero.
    assign parity_bad = ^{cfg_addr, cfg_data, cfg_parity};
`else
    assign parity_bad = 1'b0;
`endif

    assign handshake  = cfg_valid && cfg_ready;
    // A word is applied only if it targets a real tile (or broadcast) and is intact.
    assign apply_word = !dec_out_of_range && !parity_bad;
    assign next_en    = !apply_word    ? '0 :
                        dec_broadcast  ? '1 : dec_onehot;
    // A word accepted in DONE opens a new session, so counting restarts from zero.
    assign count_base = (state == DONE) ? 16'd0 : word_count;

    // Controller FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            last_word   <= 1'b0;
            cfg_ready   <= 1'b0;
            config_data <= '0;
            config_en   <= '0;
            fabric_run  <= 1'b0;
            done        <= 1'b0;
            err_addr    <= 1'b0;
            word_count  <= 16'd0;
`ifdef CFG_PARITY_EN
            err_parity  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    cfg_ready <= 1'b1;
                    if (handshake) begin
                        // Capture the word and drive the strobe during the LOAD cycle.
                        state       <= LOAD;
                        cfg_ready   <= 1'b0;
                        last_word   <= cfg_last;
                        config_data <= cfg_data;
                        config_en   <= next_en;
                        fabric_run  <= 1'b0;
                        done        <= 1'b0;
                        word_count  <= apply_word ? sat_inc(count_base) : count_base;
                        if (dec_out_of_range) begin
                            err_addr <= 1'b1;
                        end
`ifdef CFG_PARITY_EN
                        if (parity_bad) begin
                            err_parity <= 1'b1;
                        end
`endif
                    end
                end

                LOAD: begin
                    // Strobe lasts exactly one cycle; data stays on the bus while tiles settle.
                    config_en  <= '0;
                    settle_cnt <= CNT_W'(SETTLE_CYCLES);
                    state      <= SETTLE;
                end

                SETTLE: begin
                    if (settle_cnt == CNT_W'(1)) begin
                        cfg_ready <= 1'b1;
                        if (last_word) begin
                            state      <= DONE;
                            fabric_run <= 1'b1;
                            done       <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_config_ctrl.sv
// Self-checking bench for fabric_config_ctrl: directed scenarios followed by
// random words, all checked against a session-level reference model.
// Parity scenarios are compiled in when CFG_PARITY_EN is defined.
module tb_fabric_config_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [4:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        cfg_last = 1'b0;
    logic [31:0] config_data;
    logic [15:0] config_en;
    logic        fabric_run;
    logic        done;
    logic        err_addr;
    logic [15:0] word_count;
`ifdef CFG_PARITY_EN
    logic        cfg_parity = 1'b0;
    logic        err_parity;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_hs = 0;

    // Reference model state
    logic [15:0] m_wc = 16'd0;
    logic        m_err = 1'b0;
    logic        m_perr = 1'b0;
    logic        m_done = 1'b0;

    fabric_config_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_last    (cfg_last),
`ifdef CFG_PARITY_EN
        .cfg_parity  (cfg_parity),
        .err_parity  (err_parity),
`endif
        .config_data (config_data),
        .config_en   (config_en),
        .fabric_run  (fabric_run),
        .done        (done),
        .err_addr    (err_addr),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected strobe pattern from the addressing rule.
    function automatic logic [15:0] exp_mask(input logic [4:0] a);
        logic [15:0] one;
        one = 16'd1;
        if (a == 5'd31) return 16'hFFFF;
        if (a < 5'd16) return one << a;
        return 16'h0000;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(cfg_ready), 64'd0);
        chk({tag, "_data"}, 64'(config_data), 64'd0);
        chk({tag, "_en"}, 64'(config_en), 64'd0);
        chk({tag, "_run"}, 64'(fabric_run), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_erra"}, 64'(err_addr), 64'd0);
        chk({tag, "_wc"}, 64'(word_count), 64'd0);
`ifdef CFG_PARITY_EN
        chk({tag, "_errp"}, 64'(err_parity), 64'd0);
`endif
    endtask

    // Called at a negedge. Presents one word, waits for acceptance, then checks
    // the strobe cycle, the settle interval and the state when ready returns.
    task automatic send_word(input logic [4:0] a, input logic [31:0] d, input logic l,
                             input logic flip, input logic chk_gap);
        int waited;
        int hs;
        logic good;
        logic [15:0] en_exp;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        cfg_last  = l;
`ifdef CFG_PARITY_EN
        cfg_parity = (^{a, d}) ^ flip;
        good = !flip;
`else
        good = 1'b1;
`endif
        waited = 0;
        while (cfg_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            total++;
            bad++;
            $error("FAIL ready_timeout: got waited=%0d expected <20", waited);
            cfg_valid = 1'b0;
            return;
        end
        hs = cyc + 1;
        if (chk_gap) chk("hs_gap", 64'(hs - last_hs), 64'd4);
        last_hs = hs;

        if (m_done) begin
            m_wc = 16'd0;
            m_done = 1'b0;
        end
        if (a >= 5'd16 && a != 5'd31) m_err = 1'b1;
        if (!good) m_perr = 1'b1;
        if ((a < 5'd16 || a == 5'd31) && good) begin
            en_exp = exp_mask(a);
            if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
        end else begin
            en_exp = 16'h0000;
        end

        @(negedge clk);   // LOAD cycle
        cfg_valid = 1'b0;
        chk("load_en", 64'(config_en), 64'(en_exp));
        chk("load_data", 64'(config_data), 64'(d));
        chk("load_ready", 64'(cfg_ready), 64'd0);
        chk("load_run", 64'(fabric_run), 64'd0);
        chk("load_done", 64'(done), 64'd0);
        chk("load_wc", 64'(word_count), 64'(m_wc));
        chk("load_erra", 64'(err_addr), 64'(m_err));
`ifdef CFG_PARITY_EN
        chk("load_errp", 64'(err_parity), 64'(m_perr));
`endif
        @(negedge clk);   // settle 1
        chk("settle1_en", 64'(config_en), 64'd0);
        chk("settle1_ready", 64'(cfg_ready), 64'd0);
        @(negedge clk);   // settle 2
        chk("settle2_ready", 64'(cfg_ready), 64'd0);
        chk("settle2_data", 64'(config_data), 64'(d));
        chk("settle2_done", 64'(done), 64'd0);
        @(negedge clk);   // ready again
        chk("end_ready", 64'(cfg_ready), 64'd1);
        chk("end_done", 64'(done), 64'(l));
        chk("end_run", 64'(fabric_run), 64'(l));
        chk("end_wc", 64'(word_count), 64'(m_wc));
        chk("end_erra", 64'(err_addr), 64'(m_err));
        if (l) m_done = 1'b1;
    endtask

    task automatic model_reset();
        m_wc = 16'd0;
        m_err = 1'b0;
        m_perr = 1'b0;
        m_done = 1'b0;
    endtask

    initial begin
        // Reset and release
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        chk("rst_ready1", 64'(cfg_ready), 64'd1);
        chk("rst_en1", 64'(config_en), 64'd0);

        // Single word to tile 3, last
        send_word(5'd3, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);

        // Three back-to-back words: tile 0, tile 15, broadcast
        send_word(5'd0, 32'h1111_0000, 1'b0, 1'b0, 1'b1);
        send_word(5'd15, 32'h2222_0000, 1'b0, 1'b0, 1'b1);
        send_word(5'd31, 32'h3333_0000, 1'b1, 1'b0, 1'b1);
        chk("three_wc", 64'(word_count), 64'd3);

        // Out-of-range address, then a valid word
        send_word(5'd20, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        send_word(5'd7, 32'h0000_0077, 1'b1, 1'b0, 1'b1);
        chk("oor_sticky", 64'(err_addr), 64'd1);

        // Reset during settle of word 2 of 3
        send_word(5'd1, 32'h0101_0101, 1'b0, 1'b0, 1'b1);
        cfg_valid = 1'b1;
        cfg_addr  = 5'd2;
        cfg_data  = 32'h0202_0202;
        cfg_last  = 1'b0;
`ifdef CFG_PARITY_EN
        cfg_parity = ^{cfg_addr, cfg_data};
`endif
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("mid_en", 64'(config_en), 64'h0004);
        chk("mid_wc", 64'(word_count), 64'd2);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        check_reset_vals("hold_rst");
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rerun_ready", 64'(cfg_ready), 64'd1);
        chk("rerun_run", 64'(fabric_run), 64'd0);
        send_word(5'd9, 32'h0909_0909, 1'b1, 1'b0, 1'b0);
        chk("rerun_wc", 64'(word_count), 64'd1);

`ifdef CFG_PARITY_EN
        // Word with a flipped parity bit, then a good word
        send_word(5'd4, 32'h4444_4444, 1'b0, 1'b1, 1'b1);
        chk("par_err", 64'(err_parity), 64'd1);
        send_word(5'd4, 32'h4444_4445, 1'b1, 1'b0, 1'b1);
        chk("par_after_wc", 64'(word_count), 64'd1);
`endif

        // Random words against the model
        for (int i = 0; i < 40; i++) begin
            logic [4:0]  ra;
            logic [31:0] rd;
            logic        rl;
            logic        rf;
            ra = 5'($urandom_range(0, 31));
            rd = $urandom;
            rl = ($urandom_range(0, 3) == 0);
`ifdef CFG_PARITY_EN
            rf = ($urandom_range(0, 7) == 0);
`else
            rf = 1'b0;
`endif
            send_word(ra, rd, rl, rf, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
